// File: rtl/cpu_clock_controller_if.sv
// rtl/cpu_clock_controller_if.sv - operator/core control and clock-enable bundle for cpu_clock_controller
interface cpu_clock_controller_if #(
  parameter int DIV_WIDTH = 28,
  parameter int CNT_WIDTH = 32
);
  logic                 run_sw;
  logic                 step_btn;
  logic                 halt_req;
  logic [DIV_WIDTH-1:0] div_value;
  logic                 cpu_ce;
  logic                 tick_led;
  logic [1:0]           state_o;
  logic [CNT_WIDTH-1:0] ce_count;

  modport master (
    output run_sw, step_btn, halt_req, div_value,
    input  cpu_ce, tick_led, state_o, ce_count
  );

  modport slave (
    input  run_sw, step_btn, halt_req, div_value,
    output cpu_ce, tick_led, state_o, ce_count
  );
endinterface

// File: rtl/cpu_clock_controller.sv
// rtl/cpu_clock_controller.sv - run/step/halt clock-enable generator for the core
module cpu_clock_controller #(
  parameter int DIV_WIDTH       = 28,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                 clk_in,
  input  logic                 rst,
  cpu_clock_controller_if.slave bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_STEP   = 2'b10;
  localparam logic [1:0] ST_HALTED = 2'b11;

  logic [1:0]           run_sync_q;
  logic [1:0]           step_sync_q;
  logic                 run_s;
  logic                 step_s;

  logic [DB_W-1:0]      deb_cnt_q, deb_cnt_d;
  logic                 deb_lvl_q, deb_lvl_d;
  logic                 step_evt_q, step_evt_d;

  logic [1:0]           state_q, state_d;
  logic [DIV_WIDTH-1:0] period_q, period_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] div_eff;
  logic                 ce_q, ce_d;
  logic                 tick_q, tick_d;
  logic [CNT_WIDTH-1:0] ce_count_q, ce_count_d;

  assign run_s  = run_sync_q[1];
  assign step_s = step_sync_q[1];

  // A zero divisor would never produce a pulse, so it runs at full rate instead
  assign div_eff = (bus.div_value == '0) ? DIV_WIDTH'(1) : bus.div_value;

  // Two-flop synchronizers for the asynchronous switch and button
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      run_sync_q  <= '0;
      step_sync_q <= '0;
    end else begin
      run_sync_q  <= {run_sync_q[0], bus.run_sw};
      step_sync_q <= {step_sync_q[0], bus.step_btn};
    end
  end

  // Debounce: accept a new button level only after an unbroken run of mismatching cycles
  always_comb begin
    deb_cnt_d = '0;
    deb_lvl_d = deb_lvl_q;
    if (step_s != deb_lvl_q) begin
      if (deb_cnt_q == DB_LAST) begin
        deb_lvl_d = step_s;
      end else begin
        deb_cnt_d = deb_cnt_q + DB_W'(1);
      end
    end
    step_evt_d = deb_lvl_d & ~deb_lvl_q;
  end

  // Debouncer state and the one-cycle press event
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      deb_cnt_q  <= '0;
      deb_lvl_q  <= 1'b0;
      step_evt_q <= 1'b0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      deb_lvl_q  <= deb_lvl_d;
      step_evt_q <= step_evt_d;
    end
  end

  // Mode FSM; ce_d is decided one cycle ahead so cpu_ce coincides with STEP and period ends
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    div_d    = div_q;
    ce_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.halt_req) begin
          state_d = ST_HALTED;
        end else if (run_s) begin
          state_d  = ST_RUN;
          div_d    = div_eff;
          period_d = '0;
        end else if (step_evt_q) begin
          state_d = ST_STEP;
          ce_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.halt_req) begin
          state_d  = ST_HALTED;
          period_d = '0;
        end else if (!run_s) begin
          state_d  = ST_IDLE;
          period_d = '0;
        end else if (period_q == div_q - DIV_WIDTH'(1)) begin
          ce_d     = 1'b1;
          period_d = '0;
          div_d    = div_eff;
        end else begin
          period_d = period_q + DIV_WIDTH'(1);
        end
      end
      ST_STEP: begin
        state_d = bus.halt_req ? ST_HALTED : ST_IDLE;
      end
      ST_HALTED: begin
        if (!run_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    tick_d     = tick_q ^ ce_d;
    ce_count_d = ce_d ? ce_count_q + CNT_WIDTH'(1) : ce_count_q;
  end

  // FSM, period counter and registered outputs
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      period_q   <= '0;
      div_q      <= '0;
      ce_q       <= 1'b0;
      tick_q     <= 1'b0;
      ce_count_q <= '0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      div_q      <= div_d;
      ce_q       <= ce_d;
      tick_q     <= tick_d;
      ce_count_q <= ce_count_d;
    end
  end

  assign bus.cpu_ce   = ce_q;
  assign bus.tick_led = tick_q;
  assign bus.state_o  = state_q;
  assign bus.ce_count = ce_count_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// tb/tb_cpu_clock_controller.sv - directed self-checking bench for cpu_clock_controller
module tb_cpu_clock_controller;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  int   n_vec  = 0;
  int   n_err  = 0;

  cpu_clock_controller_if #(.DIV_WIDTH(28), .CNT_WIDTH(8)) bus ();

  cpu_clock_controller #(
    .DIV_WIDTH(28),
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH(8)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, output int k);
    k = 0;
    while (bus.state_o != s && k < max) begin
      tick();
      k++;
    end
  endtask

  // Cycles from the current one to the next cpu_ce; 999 on timeout
  task automatic wait_ce(input int max, output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!bus.cpu_ce && k < max);
    if (!bus.cpu_ce) k = 999;
  endtask

  int k, n_ce, n_bad, n_step, base;

  initial begin
    bus.run_sw    = 1'b0;
    bus.step_btn  = 1'b0;
    bus.halt_req  = 1'b0;
    bus.div_value = 28'd5;
    #1;
    check_vec("rst_state", 32'(bus.state_o), 32'd0);
    check_vec("rst_ce", 32'(bus.cpu_ce), 32'd0);
    check_vec("rst_count", 32'(bus.ce_count), 32'd0);
    check_vec("rst_tick", 32'(bus.tick_led), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Run at divisor 5, then change divisor mid-period
    bus.run_sw = 1'b1;
    wait_state(2'b01, 10, k);
    check_vec("run_entry", 32'(bus.state_o), 32'd1);
    wait_ce(20, k);
    check_vec("gap_first5", k, 5);
    check_vec("count1", 32'(bus.ce_count), 32'd1);
    check_vec("tick1", 32'(bus.tick_led), 32'd1);
    wait_ce(20, k);
    check_vec("gap5", k, 5);
    check_vec("count2", 32'(bus.ce_count), 32'd2);
    check_vec("tick2", 32'(bus.tick_led), 32'd0);
    tick();
    tick();
    bus.div_value = 28'd3;
    wait_ce(20, k);
    check_vec("gap_mid_change", k, 3);
    check_vec("count3", 32'(bus.ce_count), 32'd3);
    wait_ce(20, k);
    check_vec("gap3a", k, 3);
    wait_ce(20, k);
    check_vec("gap3b", k, 3);
    bus.div_value = 28'd10;
    wait_ce(20, k);
    check_vec("gap3_reload10", k, 3);
    wait_ce(20, k);
    check_vec("gap10", k, 10);
    check_vec("count7", 32'(bus.ce_count), 32'd7);

    // Drop run_sw so the synced drop lands in the cycle the pulse would be issued
    repeat (7) tick();
    bus.run_sw = 1'b0;
    n_ce = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.cpu_ce) n_ce++;
    end
    check_vec("drop_no_pulse", n_ce, 0);
    check_vec("drop_idle", 32'(bus.state_o), 32'd0);
    check_vec("drop_count", 32'(bus.ce_count), 32'd7);
    bus.run_sw = 1'b1;
    wait_state(2'b01, 10, k);
    check_vec("reentry_run", 32'(bus.state_o), 32'd1);
    wait_ce(30, k);
    check_vec("reentry_gap10", k, 10);

    // Asynchronous reset with the period counter at 3
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check_vec("arst_state", 32'(bus.state_o), 32'd0);
    check_vec("arst_count", 32'(bus.ce_count), 32'd0);
    check_vec("arst_tick", 32'(bus.tick_led), 32'd0);
    check_vec("arst_ce", 32'(bus.cpu_ce), 32'd0);
    bus.run_sw    = 1'b0;
    bus.div_value = 28'd0;
    tick();
    rst = 1'b0;
    n_ce = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.cpu_ce) n_ce++;
    end
    check_vec("post_rst_no_pulse", n_ce, 0);

    // Divisor 0 runs at full rate; 256 pulses wrap the 8-bit count
    bus.run_sw = 1'b1;
    wait_state(2'b01, 10, k);
    wait_ce(5, k);
    check_vec("div0_gap", k, 1);
    check_vec("div0_count1", 32'(bus.ce_count), 32'd1);
    n_bad = 0;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (!bus.cpu_ce) n_bad++;
    end
    check_vec("div0_every_cycle", n_bad, 0);
    check_vec("count_wrap", 32'(bus.ce_count), 32'd0);
    check_vec("tick_wrap", 32'(bus.tick_led), 32'd0);
    bus.run_sw = 1'b0;
    wait_state(2'b00, 10, k);
    check_vec("div0_exit_idle", 32'(bus.state_o), 32'd0);

    // Bounce shorter than the debounce window is rejected
    tick();
    base = int'(bus.ce_count);
    bus.step_btn = 1'b1; tick(); tick();
    bus.step_btn = 1'b0; tick();
    bus.step_btn = 1'b1; tick(); tick();
    bus.step_btn = 1'b0;
    n_ce = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.cpu_ce || bus.state_o != 2'b00) n_ce++;
    end
    check_vec("bounce_no_step", n_ce, 0);

    // Held press gives exactly one STEP pulse
    bus.step_btn = 1'b1;
    n_ce = 0; n_step = 0; n_bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 19) bus.step_btn = 1'b0;
      if (bus.cpu_ce) n_ce++;
      if (bus.state_o == 2'b10) n_step++;
      if (bus.cpu_ce && bus.state_o != 2'b10) n_bad++;
    end
    check_vec("step_pulses", n_ce, 1);
    check_vec("step_state_cycles", n_step, 1);
    check_vec("step_ce_in_step", n_bad, 0);
    check_vec("step_back_idle", 32'(bus.state_o), 32'd0);
    check_vec("step_count", 32'(bus.ce_count), 32'(8'(base + 1)));

    // Press during RUN is discarded
    bus.div_value = 28'd50;
    bus.run_sw = 1'b1;
    wait_state(2'b01, 10, k);
    bus.step_btn = 1'b1;
    n_ce = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9) bus.step_btn = 1'b0;
      if (bus.cpu_ce) n_ce++;
    end
    check_vec("run_press_no_pulse", n_ce, 0);
    bus.run_sw = 1'b0;
    wait_state(2'b00, 10, k);
    n_ce = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.cpu_ce) n_ce++;
    end
    check_vec("run_press_idle_no_pulse", n_ce, 0);

    // Halt during RUN
    bus.div_value = 28'd5;
    bus.run_sw = 1'b1;
    wait_state(2'b01, 10, k);
    wait_ce(20, k);
    check_vec("halt_pre_gap", k, 5);
    bus.halt_req = 1'b1;
    tick();
    check_vec("halt_state", 32'(bus.state_o), 32'd3);
    n_ce = 0; n_bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 5)  bus.step_btn = 1'b1;
      if (i == 25) bus.step_btn = 1'b0;
      if (i == 30) bus.halt_req = 1'b0;
      tick();
      if (bus.cpu_ce) n_ce++;
      if (bus.state_o != 2'b11) n_bad++;
    end
    check_vec("halt_no_pulse", n_ce, 0);
    check_vec("halt_held", n_bad, 0);
    bus.run_sw = 1'b0;
    tick(); tick();
    check_vec("halt_exit_sync2", 32'(bus.state_o), 32'd3);
    tick();
    check_vec("halt_exit_sync3", 32'(bus.state_o), 32'd0);

    // Halt request while idle
    bus.halt_req = 1'b1;
    tick();
    check_vec("idle_halt", 32'(bus.state_o), 32'd3);
    bus.halt_req = 1'b0;
    tick();
    check_vec("idle_halt_release", 32'(bus.state_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_clock_controller.md
Name: cpu_clock_controller

Overview:
Run/step/halt controller for the RISC-V core's execution clock. It converts the 100 MHz board clock into single-cycle clock-enable pulses (cpu_ce) at a runtime-selectable rate, or one pulse per debounced push-button press. The core runs on clk_in gated by cpu_ce, which replaces a free-running divided clock. The core can request a halt (ebreak/ecall), and the operator acknowledges the halt with the run switch.

Parameters:
DIV_WIDTH, 28, width of divisor and period counter
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a step_btn level change (10 ms at 100 MHz)
CNT_WIDTH, 32, width of ce_count

Ports:
clk_in  input  1  100 MHz board clock
rst  input  1  reset, asynchronous, active-high
run_sw  input  1  raw slide switch, asynchronous to clk_in; 1 = free-run request
step_btn  input  1  raw push button, asynchronous, bouncy; press = 1
halt_req  input  1  synchronous to clk_in, from core; 1 = stop issuing enables
div_value  input  DIV_WIDTH  run-mode period in clk_in cycles; 0 treated as 1
cpu_ce  output  1  registered single-cycle clock enable to core
tick_led  output  1  toggles on every cpu_ce pulse
state_o  output  2  current state: 00 IDLE, 01 RUN, 10 STEP, 11 HALTED
ce_count  output  CNT_WIDTH  total cpu_ce pulses issued since reset

Behaviour:
- Reset: rst is asynchronous, active-high, clock clk_in. While rst=1, all outputs are 0 and state_o is IDLE. Sync flops, debounce counter, debounced level, period counter and latched divisor (div_q) are 0. Reset mid-operation aborts any period immediately, and no pulse is emitted.
- Input conditioning: run_sw and step_btn each pass through 2-flop synchronizers.
  - Debouncer: the synced step level must differ from the debounced level for DEBOUNCE_CYCLES consecutive cycles before the debounced level updates. Any mismatch gap restarts the count.
  - step_evt is a 1-cycle pulse on the debounced rising edge. Holding the button never repeats.
- IDLE: no cpu_ce.
  - Synced run_sw=1 -> RUN. div_q <= max(div_value,1); period counter <= 0.
  - Else step_evt -> STEP.
  - run_sw has priority over step_evt in the same cycle.
- RUN: the period counter increments each cycle.
  - With div_q=N, cpu_ce is high exactly once every N cycles. The first pulse comes N cycles after the first cycle state_o shows 01.
  - At each pulse the counter wraps to 0 and div_q reloads from div_value. A divisor change therefore takes effect only at a period boundary.
  - N=1 gives cpu_ce high every cycle.
  - halt_req=1 -> HALTED next cycle, and no further pulse. A pulse already asserted in the same cycle still completes.
  - Synced run_sw=0 (without halt_req) -> IDLE. The counter is cleared, and a partial period emits no pulse.
  - halt_req has priority over run_sw=0.
  - step_evt is ignored and discarded in RUN.
- STEP: lasts exactly 1 cycle, and cpu_ce=1 during that cycle. Next state is HALTED if halt_req=1, else IDLE.
- HALTED: no cpu_ce. step_evt is ignored. Synced run_sw=0 -> IDLE. While run_sw stays 1, the block remains HALTED even if halt_req drops.
- halt_req=1 in IDLE -> HALTED.
- ce_count increments on each cpu_ce cycle and wraps from 2^CNT_WIDTH-1 to 0. tick_led inverts on each cpu_ce cycle.
- All outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
(Bench overrides DEBOUNCE_CYCLES=4 and CNT_WIDTH=8.)
1. rst=1 mid-RUN with the counter at 3 -> outputs all 0 and state_o=00 without waiting for a clk_in edge; no pulse after release.
2. run_sw=1, div_value=5:
   - Pulses are 1 cycle wide, spaced exactly 5 cycles, first 5 cycles after state_o=01. tick_led toggles and ce_count counts 1,2,3.
   - div_value->3 mid-period: the current period still takes 5 cycles, then spacing is 3.
3. div_value=0, run_sw=1 -> cpu_ce high every cycle. After 256 pulses ce_count wraps to 0.
4. Step debounce:
   - step_btn high 2 cycles, low 1, high 2 -> no pulse.
   - step_btn held 20 cycles -> exactly one cpu_ce with state_o=10 for 1 cycle, then 00.
   - Press while in RUN -> no extra pulse, and none after returning to IDLE.
5. Halt handling:
   - halt_req=1 during RUN -> state_o=11, no pulses for 50 cycles; step press ignored.
   - halt_req=0 with run_sw=1 -> still 11; run_sw=0 -> 00 after sync latency.
6. run_sw dropped 2 cycles before a due pulse at div_value=10 -> IDLE with no pulse. Re-raise -> first pulse a full 10 cycles after re-entry to RUN.
